// File: rtl/disp_bus_capture.sv
// rtl/disp_bus_capture.sv - display bus receive monitor: deglitch, frame rebuild, BCD-to-binary
// Samples the muxed {an,d} bus, rebuilds four digits, flags protocol errors and converts frames.
module disp_bus_capture #(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  an_in,
  input  logic [3:0]  d_in,
  input  logic        clear_err,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic [13:0] value_bin,
  output logic        bin_valid,
  output logic        busy,
  output logic        err_sel,
  output logic        err_digit
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [3:0] ACCEPT_AT = 4'(STABLE_CYCLES - 1);

  logic [6:0]  sync1, sync2, prev;
  logic [3:0]  stable_cnt, stable_cnt_nxt;
  logic        same, accept;
  logic [2:0]  an;
  logic [3:0]  d;
  logic        wr_ok;
  logic [3:0]  slot_bit;
  logic [15:0] shadow;
  logic [3:0]  seen;

  state_t      state, state_nxt;
  logic [15:0] work;
  logic [13:0] acc, acc_step;
  logic [1:0]  idx;
  logic [3:0]  cur_digit;
  logic        pending, load, finish;

  // Input stage: two-flop synchronizer plus run-length counter on the synced bus value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      stable_cnt <= '0;
    end else begin
      sync1      <= {an_in, d_in};
      sync2      <= sync1;
      prev       <= sync2;
      stable_cnt <= stable_cnt_nxt;
    end
  end

  always_comb begin
    same = (sync2 == prev);
    if (!same)
      stable_cnt_nxt = '0;
    else if (stable_cnt == 4'd15)
      stable_cnt_nxt = 4'd15;
    else
      stable_cnt_nxt = stable_cnt + 4'd1;
    // Fires on the transition into ACCEPT_AT only, so one accept per stable run
    accept = (stable_cnt_nxt == ACCEPT_AT) && (!same || (stable_cnt != stable_cnt_nxt));
  end

  assign an       = sync2[6:4];
  assign d        = sync2[3:0];
  assign wr_ok    = accept && !an[0] && (d <= 4'd9);
  assign slot_bit = 4'b0001 << an[2:1];

  // Slot shadow, seen mask and frame publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      seen        <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (wr_ok)
        shadow[{an[2:1], 2'b00} +: 4] <= d;
      if (seen == 4'hF) begin
        digits      <= shadow;
        frame_valid <= 1'b1;
        seen        <= wr_ok ? slot_bit : 4'b0000;
      end else begin
        frame_valid <= 1'b0;
        if (wr_ok)
          seen <= seen | slot_bit;
      end
    end
  end

  // Sticky error flags: a set event outranks a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel   <= 1'b0;
      err_digit <= 1'b0;
    end else begin
      if (accept && an[0])
        err_sel <= 1'b1;
      else if (clear_err)
        err_sel <= 1'b0;

      if (accept && !an[0] && (d > 4'd9))
        err_digit <= 1'b1;
      else if (clear_err)
        err_digit <= 1'b0;
    end
  end

  // Converter FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (frame_valid) begin
          state_nxt = CONV;
          load      = 1'b1;
        end
      end
      CONV: begin
        if (idx == 2'd0) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      DONE: begin
        // A frame landing exactly in DONE is folded in the same way as a pending one
        if (pending || frame_valid) begin
          state_nxt = CONV;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cur_digit = work[{idx, 2'b00} +: 4];
  assign acc_step  = (acc << 3) + (acc << 1) + {10'd0, cur_digit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      acc       <= '0;
      idx       <= '0;
      pending   <= 1'b0;
      value_bin <= '0;
      bin_valid <= 1'b0;
    end else begin
      if (load) begin
        work <= digits;
        acc  <= '0;
        idx  <= 2'd3;
      end else if (state == CONV) begin
        acc <= acc_step;
        idx <= idx - 2'd1;
      end

      if (finish) begin
        value_bin <= acc_step;
        bin_valid <= 1'b1;
      end else begin
        bin_valid <= 1'b0;
      end

      if ((state == CONV) && frame_valid)
        pending <= 1'b1;
      else if (state == DONE)
        pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_disp_bus_capture.sv
// tb/tb_disp_bus_capture.sv - directed table-driven bench for disp_bus_capture
module tb_disp_bus_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  an_in;
  logic [3:0]  d_in;
  logic        clear_err;

  logic [15:0] digits0, digits1;
  logic        frame_valid0, frame_valid1;
  logic [13:0] value_bin0, value_bin1;
  logic        bin_valid0, bin_valid1;
  logic        busy0, busy1;
  logic        err_sel0, err_sel1;
  logic        err_digit0, err_digit1;

  int checks = 0;
  int failures = 0;
  int fv0 = 0;
  int bv0 = 0;
  logic [13:0] bval0 = '0;

  always #5 clk = ~clk;

  disp_bus_capture #(.STABLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .an_in(an_in), .d_in(d_in), .clear_err(clear_err),
    .digits(digits0), .frame_valid(frame_valid0), .value_bin(value_bin0),
    .bin_valid(bin_valid0), .busy(busy0), .err_sel(err_sel0), .err_digit(err_digit0)
  );

  disp_bus_capture #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .an_in(an_in), .d_in(d_in), .clear_err(clear_err),
    .digits(digits1), .frame_valid(frame_valid1), .value_bin(value_bin1),
    .bin_valid(bin_valid1), .busy(busy1), .err_sel(err_sel1), .err_digit(err_digit1)
  );

  always @(negedge clk) begin
    if (frame_valid0) fv0++;
    if (bin_valid0) begin
      bv0++;
      bval0 = value_bin0;
    end
  end

  typedef struct {
    logic [2:0]  an;
    logic [3:0]  d;
    int          hold;
    logic        clr;
    int          fv;
    int          bv;
    logic [13:0] bval;
    logic [15:0] dig;
    logic        esel;
    logic        edig;
  } vec_t;

  vec_t tbl [20];
  logic [6:0] b2b [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] a, input logic [3:0] v, input int n);
    an_in = a;
    d_in  = v;
    step(n);
  endtask

  task automatic wait_fv0(input string name);
    int c;
    c = 0;
    while (!frame_valid0 && c < 30) begin
      step(1);
      c++;
    end
    check(name, frame_valid0, 1);
  endtask

  task automatic wait_bv0(input string name);
    int c;
    c = 0;
    while (!bin_valid0 && c < 30) begin
      step(1);
      c++;
    end
    check(name, bin_valid0, 1);
  endtask

  initial begin
    int bv_before;
    int n_fv, n_bv, fv_first, fv_last, gap;
    logic [13:0] bvals [2];
    int bcyc [2];

    //         an      d    hold clr fv bv bval      digits    esel  edig
    tbl[0]  = '{3'b000, 4'h4, 5, 1'b0, 0, 0, 14'd0,    16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{3'b010, 4'h3, 5, 1'b0, 0, 0, 14'd0,    16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{3'b100, 4'h2, 5, 1'b0, 0, 0, 14'd0,    16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{3'b110, 4'h1, 5, 1'b0, 1, 0, 14'd0,    16'h1234, 1'b0, 1'b0};
    tbl[4]  = '{3'b000, 4'h5, 5, 1'b0, 1, 1, 14'd1234, 16'h1234, 1'b0, 1'b0};
    tbl[5]  = '{3'b010, 4'h7, 1, 1'b0, 1, 1, 14'd1234, 16'h1234, 1'b0, 1'b0};
    tbl[6]  = '{3'b100, 4'h6, 5, 1'b0, 1, 1, 14'd1234, 16'h1234, 1'b0, 1'b0};
    tbl[7]  = '{3'b110, 4'h7, 5, 1'b0, 1, 1, 14'd1234, 16'h1234, 1'b0, 1'b0};
    tbl[8]  = '{3'b010, 4'hA, 5, 1'b0, 1, 1, 14'd1234, 16'h1234, 1'b0, 1'b1};
    tbl[9]  = '{3'b011, 4'h5, 5, 1'b0, 1, 1, 14'd1234, 16'h1234, 1'b1, 1'b1};
    tbl[10] = '{3'b010, 4'h8, 5, 1'b0, 2, 1, 14'd1234, 16'h7685, 1'b1, 1'b1};
    tbl[11] = '{3'b000, 4'h9, 5, 1'b1, 2, 2, 14'd7685, 16'h7685, 1'b0, 1'b0};
    tbl[12] = '{3'b010, 4'h9, 5, 1'b0, 2, 2, 14'd7685, 16'h7685, 1'b0, 1'b0};
    tbl[13] = '{3'b100, 4'h9, 5, 1'b0, 2, 2, 14'd7685, 16'h7685, 1'b0, 1'b0};
    tbl[14] = '{3'b110, 4'h9, 5, 1'b0, 3, 2, 14'd7685, 16'h9999, 1'b0, 1'b0};
    tbl[15] = '{3'b000, 4'h0, 5, 1'b0, 3, 3, 14'd9999, 16'h9999, 1'b0, 1'b0};
    tbl[16] = '{3'b010, 4'h0, 5, 1'b0, 3, 3, 14'd9999, 16'h9999, 1'b0, 1'b0};
    tbl[17] = '{3'b100, 4'h0, 5, 1'b0, 3, 3, 14'd9999, 16'h9999, 1'b0, 1'b0};
    tbl[18] = '{3'b110, 4'h0, 5, 1'b0, 4, 3, 14'd9999, 16'h0000, 1'b0, 1'b0};
    tbl[19] = '{3'b000, 4'h3, 5, 1'b0, 4, 4, 14'd0,    16'h0000, 1'b0, 1'b0};

    b2b[0] = {3'b000, 4'h9};
    b2b[1] = {3'b010, 4'h0};
    b2b[2] = {3'b100, 4'h0};
    b2b[3] = {3'b110, 4'h0};
    b2b[4] = {3'b000, 4'h9};
    b2b[5] = {3'b010, 4'h9};
    b2b[6] = {3'b100, 4'h9};
    b2b[7] = {3'b110, 4'h9};

    rst = 1'b1;
    an_in = 3'b000;
    d_in = 4'h0;
    clear_err = 1'b0;
    step(3);
    check("rst_digits", digits0, 0);
    check("rst_fv", frame_valid0, 0);
    check("rst_value", value_bin0, 0);
    check("rst_bv", bin_valid0, 0);
    check("rst_busy", busy0, 0);
    check("rst_err_sel", err_sel0, 0);
    check("rst_err_digit", err_digit0, 0);
    rst = 1'b0;
    step(2);

    for (int i = 0; i < 20; i++) begin
      an_in = tbl[i].an;
      d_in = tbl[i].d;
      clear_err = tbl[i].clr;
      step(tbl[i].hold);
      check($sformatf("row%0d_frames", i), fv0, tbl[i].fv);
      check($sformatf("row%0d_bins", i), bv0, tbl[i].bv);
      check($sformatf("row%0d_value", i), bval0, tbl[i].bval);
      check($sformatf("row%0d_digits", i), digits0, tbl[i].dig);
      check($sformatf("row%0d_err_sel", i), err_sel0, tbl[i].esel);
      check($sformatf("row%0d_err_digit", i), err_digit0, tbl[i].edig);
    end
    clear_err = 1'b0;

    an_in = 3'b011;
    d_in = 4'h2;
    step(3);
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    check("set_beats_clear_err_sel", err_sel0, 1);
    check("set_beats_clear_err_digit", err_digit0, 0);
    step(2);
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    check("clear_pulse_err_sel", err_sel0, 0);
    check("clear_pulse_err_digit", err_digit0, 0);

    drive(3'b010, 4'h5, 5);
    drive(3'b100, 4'h6, 5);
    an_in = 3'b110;
    d_in = 4'h7;
    wait_fv0("pre_rst_frame_timeout");
    check("pre_rst_digits", digits0, 16'h7653);
    wait_bv0("pre_rst_bin_timeout");
    check("pre_rst_value", value_bin0, 7653);
    drive(3'b001, 4'h0, 5);
    check("pre_rst_err_sel", err_sel0, 1);
    drive(3'b000, 4'h1, 5);
    drive(3'b010, 4'h2, 5);
    drive(3'b100, 4'h3, 5);
    an_in = 3'b110;
    d_in = 4'h4;
    wait_fv0("abort_frame_timeout");
    step(2);
    check("abort_busy_before", busy0, 1);
    bv_before = bv0;
    rst = 1'b1;
    #1;
    check("abort_digits", digits0, 0);
    check("abort_value", value_bin0, 0);
    check("abort_busy", busy0, 0);
    check("abort_bv", bin_valid0, 0);
    check("abort_fv", frame_valid0, 0);
    check("abort_err_sel", err_sel0, 0);
    an_in = 3'b000;
    d_in = 4'h8;
    step(2);
    rst = 1'b0;
    step(5);
    check("abort_no_bin", bv0, bv_before);
    drive(3'b010, 4'h7, 5);
    drive(3'b100, 4'h6, 5);
    an_in = 3'b110;
    d_in = 4'h5;
    wait_fv0("post_rst_frame_timeout");
    check("post_rst_digits", digits0, 16'h5678);
    wait_bv0("post_rst_bin_timeout");
    check("post_rst_value", value_bin0, 5678);
    check("post_rst_bin_count", bv0, bv_before + 1);

    rst = 1'b1;
    step(2);
    an_in = b2b[0][6:4];
    d_in = b2b[0][3:0];
    rst = 1'b0;
    n_fv = 0;
    n_bv = 0;
    fv_first = 0;
    fv_last = 0;
    gap = 0;
    bvals[0] = '0;
    bvals[1] = '0;
    bcyc[0] = 0;
    bcyc[1] = 0;
    for (int c = 0; c < 40 && n_bv < 2; c++) begin
      if (c < 8) begin
        an_in = b2b[c][6:4];
        d_in = b2b[c][3:0];
      end
      step(1);
      if (frame_valid1) begin
        if (n_fv == 0) fv_first = c;
        fv_last = c;
        n_fv++;
      end
      if (n_fv > 0 && c > fv_first && !busy1) gap = 1;
      if (bin_valid1) begin
        bvals[n_bv] = value_bin1;
        bcyc[n_bv] = c;
        n_bv++;
      end
    end
    check("b2b_bins_seen", n_bv, 2);
    check("b2b_frames_seen", n_fv, 2);
    check("b2b_frame_spacing", fv_last - fv_first, 4);
    check("b2b_first_value", bvals[0], 9);
    check("b2b_second_value", bvals[1], 9999);
    check("b2b_bin_spacing", bcyc[1] - bcyc[0], 5);
    check("b2b_first_latency", bcyc[0] - fv_first, 5);
    check("b2b_busy_gap", gap, 0);
    check("b2b_digits", digits1, 16'h9999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
